alu_bitop_seq: RTL and testbench

Slice-serial bit-manipulation unit for the CB-prefix bit-operation group: BIT, SET, RES, plus a new TGL (toggle) mode. It takes a DATA_W-bit operand and a bit index, and processes the operand SLICE_W bits per cycle, LSB slice first, like the nibble-wide core ALU. The core sequencer drives it with a start/busy/done handshake, and it returns the result plus Z/N/H flags with a flag write-enable. DATA_W and SLICE_W are parameters, so the same block serves the 8-bit datapath and 16-bit or other variants.

---
 rtl/alu_bitop_seq.sv | 156 +++++++++++++++
 tb/tb_alu_bitop_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_bitop_seq.sv
// Slice-serial BIT/SET/RES/TGL unit, SLICE_W bits per cycle, LSB slice first; done is DATA_W/SLICE_W+1 cycles after start.
// No backpressure: start is taken only in IDLE or in the done cycle and ignored while busy.
module alu_bitop_seq #(
   parameter int DATA_W  = 8,
   parameter int SLICE_W = 4,
   localparam int NS     = DATA_W / SLICE_W,
   localparam int IDX_W  = ($clog2(DATA_W) > 1) ? $clog2(DATA_W) : 1
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] opA,
   input  logic [IDX_W-1:0]  opB,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              flag_z,
   output logic              flag_n,
   output logic              flag_h,
   output logic              flags_we
);

   localparam int CNT_W = ($clog2(NS) > 1) ? $clog2(NS) : 1;
   localparam logic [1:0] OP_BIT = 2'b00;
   localparam logic [1:0] OP_SET = 2'b01;
   localparam logic [1:0] OP_RES = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [1:0]          op_q, op_d;
   logic [DATA_W-1:0]   work_q, work_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                bit_q, bit_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic                z_q, z_d, n_q, n_d, h_q, h_d;

   logic [SLICE_W-1:0]  slice, mask, new_slice;
   int                  rel;
   logic                in_range;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      work_d   = work_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      we_d     = 1'b0;
      result_d = result_q;
      z_d      = z_q;
      n_d      = n_q;
      h_d      = h_q;

      // Mask is empty unless the index falls inside the slice currently at the bottom of work_q.
      slice    = work_q[SLICE_W-1:0];
      rel      = int'(idx_q) - int'(cnt_q) * SLICE_W;
      in_range = int'(idx_q) < DATA_W;
      mask     = '0;
      for (int i = 0; i < SLICE_W; i++) begin
         mask[i] = in_range && (rel == i);
      end

      case (op_q)
         OP_SET:  new_slice = slice | mask;
         OP_RES:  new_slice = slice & ~mask;
         OP_BIT:  new_slice = slice;
         default: new_slice = slice ^ mask;
      endcase

      case (state_q)
         S_RUN: begin
            // Rotate right by one slice; after NS steps the result is back in place.
            work_d = (work_q >> SLICE_W) | (DATA_W'(new_slice) << (DATA_W - SLICE_W));
            if (|mask) begin
               bit_d = |(slice & mask);
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(NS - 1)) begin
               state_d  = S_DONE;
               done_d   = 1'b1;
               result_d = work_d;
               if (op_q == OP_BIT) begin
                  we_d = 1'b1;
                  z_d  = ~bit_d;
                  n_d  = 1'b0;
                  h_d  = 1'b1;
               end
            end else begin
               busy_d = 1'b1;
            end
         end
         default: begin
            if (start) begin
               state_d = S_RUN;
               op_d    = op;
               work_d  = opA;
               idx_d   = opB;
               cnt_d   = '0;
               bit_d   = 1'b0;
               busy_d  = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         work_q   <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         bit_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         we_q     <= 1'b0;
         result_q <= '0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
         h_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         work_q   <= work_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         we_q     <= we_d;
         result_q <= result_d;
         z_q      <= z_d;
         n_q      <= n_d;
         h_q      <= h_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign flag_z   = z_q;
   assign flag_n   = n_q;
   assign flag_h   = h_q;
   assign flags_we = we_q;

endmodule

// File: tb/tb_alu_bitop_seq.sv
// Directed bench for alu_bitop_seq: default 8/4 instance plus 16/4 and 8/8 variants.
module tb_alu_bitop_seq;

   localparam logic [1:0] BIT = 2'b00, SET = 2'b01, RES = 2'b10, TGL = 2'b11;

   logic clk = 1'b0;
   logic nreset;
   always #5 clk = ~clk;

   // default instance
   logic       start;
   logic [1:0] op;
   logic [7:0] opa;
   logic [2:0] opb;
   logic       busy, done, fz, fn, fh, fwe;
   logic [7:0] res;

   // 16-bit, 4-bit slices
   logic        st16;
   logic [1:0]  op16;
   logic [15:0] a16, res16;
   logic [3:0]  b16;
   logic        busy16, done16, fz16, fn16, fh16, fwe16;

   // 8-bit, single slice
   logic       stw;
   logic [1:0] opw;
   logic [7:0] aw, resw;
   logic [2:0] bw;
   logic       busyw, donew, fzw, fnw, fhw, fwew;

   alu_bitop_seq #(.DATA_W(8), .SLICE_W(4)) dut (
      .clk(clk), .nreset(nreset), .start(start), .op(op), .opA(opa), .opB(opb),
      .busy(busy), .done(done), .result(res), .flag_z(fz), .flag_n(fn), .flag_h(fh), .flags_we(fwe));

   alu_bitop_seq #(.DATA_W(16), .SLICE_W(4)) dut16 (
      .clk(clk), .nreset(nreset), .start(st16), .op(op16), .opA(a16), .opB(b16),
      .busy(busy16), .done(done16), .result(res16), .flag_z(fz16), .flag_n(fn16), .flag_h(fh16), .flags_we(fwe16));

   alu_bitop_seq #(.DATA_W(8), .SLICE_W(8)) dutw (
      .clk(clk), .nreset(nreset), .start(stw), .op(opw), .opA(aw), .opB(bw),
      .busy(busyw), .done(donew), .result(resw), .flag_z(fzw), .flag_n(fnw), .flag_h(fhw), .flags_we(fwew));

   int n_vec = 0;
   int n_bad = 0;
   logic hz = 1'b0, hn = 1'b0, hh = 1'b0;   // expected held flags

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Called at a negedge; returns at the negedge of the done cycle.
   task automatic do_op(input string tag, input logic [1:0] o, input logic [7:0] a,
                        input logic [2:0] b, input logic [7:0] er, input logic ez,
                        input bit poke);
      start = 1'b1; op = o; opa = a; opb = b;
      @(negedge clk);
      start = 1'b0; opa = ~a; opb = b + 3'd1;
      for (int i = 0; i < 2; i++) begin
         chk({tag, "_busy"}, 32'(busy), 32'd1);
         chk({tag, "_nodone"}, 32'(done), 32'd0);
         if (poke && i == 0) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      if (o == BIT) begin
         hz = ez; hn = 1'b0; hh = 1'b1;
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
      chk({tag, "_res"}, 32'(res), 32'(er));
      chk({tag, "_we"}, 32'(fwe), (o == BIT) ? 32'd1 : 32'd0);
      chk({tag, "_flags"}, 32'({fz, fn, fh}), 32'({hz, hn, hh}));
   endtask

   initial begin
      int cyc;
      nreset = 1'b0;
      start = 1'b0; op = SET; opa = 8'h00; opb = 3'd0;
      st16 = 1'b0; op16 = SET; a16 = 16'h0; b16 = 4'd0;
      stw = 1'b0; opw = RES; aw = 8'h0; bw = 3'd0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_res", 32'(res), 32'd0);
      chk("rst_flags", 32'({fz, fn, fh, fwe}), 32'd0);
      nreset = 1'b1;
      @(negedge clk);

      // BIT on 0x5A = 0101_1010
      do_op("bit1", BIT, 8'h5A, 3'd1, 8'h5A, 1'b0, 1'b0); @(negedge clk);
      chk("post_done", 32'(done), 32'd0);
      chk("post_we", 32'(fwe), 32'd0);
      do_op("bit0", BIT, 8'h5A, 3'd0, 8'h5A, 1'b1, 1'b0); @(negedge clk);
      do_op("bit7", BIT, 8'h5A, 3'd7, 8'h5A, 1'b1, 1'b0); @(negedge clk);
      do_op("bit6", BIT, 8'h5A, 3'd6, 8'h5A, 1'b0, 1'b0); @(negedge clk);

      // SET sweep; flags must hold the last BIT values
      do_op("set5", SET, 8'h00, 3'd5, 8'h20, 1'b0, 1'b0); @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         do_op("setsw", SET, 8'h00, 3'(k), 8'(1 << k), 1'b0, 1'b0); @(negedge clk);
      end

      do_op("res7", RES, 8'hFF, 3'd7, 8'h7F, 1'b0, 1'b0); @(negedge clk);
      do_op("res0", RES, 8'hFF, 3'd0, 8'hFE, 1'b0, 1'b0); @(negedge clk);
      do_op("res4", RES, 8'hFF, 3'd4, 8'hEF, 1'b0, 1'b0); @(negedge clk);

      // TGL back-to-back: second start lands in the done cycle
      do_op("tgl_a", TGL, 8'h5A, 3'd3, 8'h52, 1'b0, 1'b0);
      do_op("tgl_b", TGL, 8'h52, 3'd3, 8'h5A, 1'b0, 1'b0); @(negedge clk);
      do_op("tgl6", TGL, 8'h5A, 3'd6, 8'h1A, 1'b0, 1'b0); @(negedge clk);

      // start during RUN is ignored: exactly one done
      do_op("poke", SET, 8'h81, 3'd2, 8'h85, 1'b0, 1'b1);
      cyc = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done || busy) cyc++;
      end
      chk("poke_single", 32'(cyc), 32'd0);

      // reset mid-RUN aborts
      start = 1'b1; op = SET; opa = 8'h00; opb = 3'd5;
      @(negedge clk);
      start = 1'b0;
      chk("abort_busy_pre", 32'(busy), 32'd1);
      nreset = 1'b0;
      @(negedge clk);
      nreset = 1'b1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_res", 32'(res), 32'd0);
      chk("abort_flags", 32'({fz, fn, fh, fwe}), 32'd0);
      cyc = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done) cyc++;
      end
      chk("abort_nodone", 32'(cyc), 32'd0);
      hz = 1'b0; hn = 1'b0; hh = 1'b0;

      // 16-bit: SET idx 15, done 5 cycles after start edge
      st16 = 1'b1; op16 = SET; a16 = 16'h0000; b16 = 4'd15;
      @(negedge clk);
      st16 = 1'b0; a16 = 16'hFFFF;
      cyc = 1;
      while (!done16 && cyc < 12) begin
         @(negedge clk);
         cyc++;
      end
      chk("w16_lat", 32'(cyc), 32'd5);
      chk("w16_res", 32'(res16), 32'h8000);
      chk("w16_we", 32'({busy16, fwe16}), 32'd0);

      // single-slice: RES idx 3, done 2 cycles after start edge
      stw = 1'b1; opw = RES; aw = 8'hFF; bw = 3'd3;
      @(negedge clk);
      stw = 1'b0;
      cyc = 1;
      while (!donew && cyc < 12) begin
         @(negedge clk);
         cyc++;
      end
      chk("w8_lat", 32'(cyc), 32'd2);
      chk("w8_res", 32'(resw), 32'hF7);
      chk("w8_we", 32'({busyw, fwew}), 32'd0);
      chk("var_flags", 32'({fz16, fn16, fh16, fzw, fnw, fhw}), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
